hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Hazard scheduler for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
//  Detects load-use and branch hazards; drives PC/IF-ID write enables, bubble and flush strobes.
//  Drives EX-stage operand forwarding selects.
//  Sits beside the inter-stage registers and is the only block that stalls or squashes them.
// PARAMETERS
//  LOAD_STALL  default 1   bubble cycles inserted per load-use hazard (1..3)
//  BR_PENALTY  default 3   younger instructions squashed on taken branch (resolved in MEM)
//  CNT_W       default 32  width of performance counters
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  Rn_id         in   5      ID source A register
//  Rm_id         in   5      ID source B register (post-Reg2Loc mux)
//  Rn_ex, Rm_ex  in   5      EX source registers (forwarding compare)
//  Rd_ex         in   5      EX destination
//  MemtoReg_ex   in   1      EX instruction is a load
//  RegWrite_ex   in   1      EX instruction writes a register
//  Rd_mem        in   5      MEM destination
//  RegWrite_mem  in   1      MEM instruction writes a register
//  Rd_wb         in   5      WB destination
//  RegWrite_wb   in   1      WB instruction writes a register
//  BrTaken_mem   in   1      taken branch resolved in MEM
//  pc_write      out  1      0 = hold PC
//  if_id_write   out  1      0 = hold IF/ID
//  id_ex_bubble  out  1      1 = load NOP controls into ID/EX
//  flush_if_id   out  1      squash IF/ID
//  flush_ex_mem  out  1      squash EX/MEM
//  fwd_a, fwd_b  out  2      EX operand select: 00 regfile, 01 WB, 10 MEM
//  stall_cnt     out  CNT_W  load-use stall cycles (perf)
//  flush_cnt     out  CNT_W  taken-branch events (perf)
// BEHAVIOUR
//  FSM states RUN, STALL, FLUSH; 2-bit down-counter cnt. Reset: RUN, cnt=0, all strobes 0.
//  Reset: pc_write=if_id_write=1, fwd_*=00, counters 0. Reset mid-stall/flush returns to RUN immediately.
//  load_use = MemtoReg_ex & RegWrite_ex & Rd_ex!=31 & (Rd_ex==Rn_id | Rd_ex==Rm_id).
//  RUN:
//   - BrTaken_mem: same cycle assert flush_if_id, id_ex_bubble, flush_ex_mem.
//     If BR_PENALTY>3, go FLUSH with cnt=BR_PENALTY-4; else stay RUN.
//   - else load_use: same cycle pc_write=if_id_write=0, id_ex_bubble=1.
//     If LOAD_STALL>1, go STALL with cnt=LOAD_STALL-2.
//  STALL: hold PC/IF-ID, bubble each cycle; cnt==0 -> RUN, else cnt--. BrTaken_mem preempts: flush as RUN, -> RUN.
//  FLUSH: flush_if_id=id_ex_bubble=1; cnt==0 -> RUN, else cnt--.
//  Simultaneous BrTaken_mem and load_use: branch wins, no stall (stalled instr is squashed).
//  Forwarding (combinational, no latency):
//   fwd_a=10 if RegWrite_mem & Rd_mem!=31 & Rd_mem==Rn_ex.
//   else 01 if RegWrite_wb & Rd_wb!=31 & Rd_wb==Rn_ex.
//   else 00. fwd_b identical against Rm_ex. MEM beats WB. X31 never forwarded.
//  Counters: stall_cnt++ each cycle pc_write==0; flush_cnt++ per BrTaken_mem in RUN/STALL. Saturate at all-ones.
// CONFIGURATION
//  HAZARD_PERF_EN defined: stall_cnt/flush_cnt implemented as above.
//  Undefined: counters not built; ports remain, tied to 0.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), hz_state_t enum (RUN, STALL, FLUSH), XZR=5'd31.
//  Sub-module forward_unit: pure combinational fwd_a/fwd_b, instantiated once.
// TESTING
//  LDUR X1 in EX (Rd_ex=1, MemtoReg_ex=1), ADD reading Rn_id=1 -> 1 cycle pc_write=0, id_ex_bubble=1, then RUN.
//  Same with Rd_ex=31 -> no stall; pc_write stays 1.
//  BrTaken_mem=1 in RUN, BR_PENALTY=3 -> flush_if_id=id_ex_bubble=flush_ex_mem=1 for 1 cycle.
//  BrTaken_mem and load_use same cycle -> flushes asserted, pc_write=1, flush_cnt+1, stall_cnt unchanged.
//  Rd_mem=Rd_wb=5=Rn_ex, both RegWrite -> fwd_a=10; clear RegWrite_mem -> fwd_a=01.
//  LOAD_STALL=3, reset pulsed in 2nd stall cycle -> RUN, pc_write=1, counters 0 next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 hazard scheduler: forwarding selects, FSM states
// and the zero-register index that must never be forwarded or stall-matched.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

  // MEM result is younger than WB, so it takes priority when both match.
  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic [4:0] rd_mem,
    input logic       wr_mem,
    input logic [4:0] rd_wb,
    input logic       wr_wb
  );
    if (wr_mem && (rd_mem != XZR) && (rd_mem == src))
      return FWD_MEM;
    else if (wr_wb && (rd_wb != XZR) && (rd_wb == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding selects; purely combinational, no latency.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rn_ex,
  input  logic [4:0] Rm_ex,
  input  logic [4:0] Rd_mem,
  input  logic       RegWrite_mem,
  input  logic [4:0] Rd_wb,
  input  logic       RegWrite_wb,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  assign fwd_a = fwd_pick(Rn_ex, Rd_mem, RegWrite_mem, Rd_wb, RegWrite_wb);
  assign fwd_b = fwd_pick(Rm_ex, Rd_mem, RegWrite_mem, Rd_wb, RegWrite_wb);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage LEGv8 pipeline: load-use stalls, taken-branch
// squashes and forwarding selects. Define HAZARD_PERF_EN to build the perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int BR_PENALTY = 3,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Rm_id,
  input  logic [4:0]       Rn_ex,
  input  logic [4:0]       Rm_ex,
  input  logic [4:0]       Rd_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic [4:0]       Rd_mem,
  input  logic             RegWrite_mem,
  input  logic [4:0]       Rd_wb,
  input  logic             RegWrite_wb,
  input  logic             BrTaken_mem,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The first stall/flush cycle happens in RUN, so the counter covers the rest.
  localparam logic [1:0] LD_CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;
  localparam logic [1:0] BR_CNT_INIT = (BR_PENALTY > 3) ? 2'(BR_PENALTY - 4) : 2'd0;

  hz_state_t  state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       load_use;
  logic       br_evt;
  fwd_sel_t   fwd_a_sel, fwd_b_sel;

  assign load_use = MemtoReg_ex && RegWrite_ex && (Rd_ex != XZR) &&
                    ((Rd_ex == Rn_id) || (Rd_ex == Rm_id));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_ex_mem = 1'b0;
    br_evt       = 1'b0;
    case (state)
      RUN: begin
        if (BrTaken_mem) begin
          // Branch wins over a concurrent load-use: the stalled instruction dies anyway.
          flush_if_id  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_ex_mem = 1'b1;
          br_evt       = 1'b1;
          if (BR_PENALTY > 3) begin
            state_nx = FLUSH;
            cnt_nx   = BR_CNT_INIT;
          end
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nx = STALL;
            cnt_nx   = LD_CNT_INIT;
          end
        end
      end
      STALL: begin
        if (BrTaken_mem) begin
          flush_if_id  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_ex_mem = 1'b1;
          br_evt       = 1'b1;
          state_nx     = RUN;
          cnt_nx       = 2'd0;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt == 2'd0) state_nx = RUN;
          else             cnt_nx   = cnt - 2'd1;
        end
      end
      FLUSH: begin
        flush_if_id  = 1'b1;
        id_ex_bubble = 1'b1;
        if (cnt == 2'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 2'd1;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  forward_unit u_fwd (
    .Rn_ex        (Rn_ex),
    .Rm_ex        (Rm_ex),
    .Rd_mem       (Rd_mem),
    .RegWrite_mem (RegWrite_mem),
    .Rd_wb        (Rd_wb),
    .RegWrite_wb  (RegWrite_wb),
    .fwd_a        (fwd_a_sel),
    .fwd_b        (fwd_b_sel)
  );

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
      if (br_evt)    flush_cnt <= sat_inc(flush_cnt);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
